// File: rtl/kamus_pkg.sv
// kamus_pkg: shared LSU types, byte-enable constants and op helpers
package kamus_pkg;
  typedef enum logic [3:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} lsu_op_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  function automatic logic is_store(lsu_op_t op);
    return op inside {SB, SH, SW};
  endfunction
endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: store byte-enable/lane replication and load lane extraction with extension
module kamus_lsu_align
  import kamus_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);
  logic [31:0] sh;
  logic [7:0]  b;
  logic [15:0] h;
  assign sh = rdata >> {off, 3'b000};
  assign b  = sh[7:0];
  assign h  = off[1] ? rdata[31:16] : rdata[15:0];
  always_comb begin
    be        = op == SB ? 4'b0001 << off : op == SH ? (off[1] ? 4'b1100 : 4'b0011) : BE_ALL;
    wdata_rep = op == SB ? {4{wdata[7:0]}} : op == SH ? {2{wdata[15:0]}} : wdata;
    rdata_fmt = op == LB  ? {{24{b[7]}}, b} :
                op == LBU ? {24'd0, b} :
                op == LH  ? {{16{h[15]}}, h} :
                op == LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/kamus_lsu.sv
// kamus_lsu: single-transaction load/store controller (req/gnt/rvalid data-memory port)
// Optional misaligned-access trap: define KAMUS_LSU_MISALIGN_TRAP_EN
module kamus_lsu
  import kamus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  lsu_op_t           op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [RD_W-1:0]   resp_rd_o,
  output logic              resp_we_o,
  output logic              busy_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i
);
  lsu_state_e        state, state_n;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, fmt, wrep;
  logic [RD_W-1:0]   rd_q;
  logic [3:0]        be;
  logic              killed, mis, mis_q, accept, st;

`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
  assign mis = (op_i inside {LH, LHU, SH} && addr_i[0]) || (op_i inside {LW, SW} && addr_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  assign accept = state == IDLE && req_valid_i && !flush_i;
  assign st     = is_store(op_q);

  kamus_lsu_align u_align (
    .op(op_q), .off(addr_q[1:0]), .wdata(wdata_q), .rdata(dmem_rdata_i),
    .be(be), .wdata_rep(wrep), .rdata_fmt(fmt)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = mis ? RESP : REQ;
      REQ:     if (dmem_gnt_i) state_n = WAIT; else if (flush_i) state_n = IDLE;
      WAIT:    if (dmem_rvalid_i) state_n = (killed || flush_i) ? IDLE : RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      killed  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        rd_q    <= rd_i;
        killed  <= 1'b0;
        mis_q   <= mis;
        rdata_q <= 32'(addr_i);
      end
      // A flush after the grant cannot recall the access; remember to drop its response
      if ((state == REQ && dmem_gnt_i && flush_i) || (state == WAIT && flush_i)) killed <= 1'b1;
      if (state == WAIT && dmem_rvalid_i) rdata_q <= st ? '0 : fmt;
    end
  end

  assign req_ready_o  = state == IDLE;
  assign busy_o       = state != IDLE;
  assign dmem_req_o   = state == REQ;
  assign dmem_we_o    = dmem_req_o && st;
  assign dmem_be_o    = dmem_req_o ? be : BE_NONE;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata_o = dmem_req_o ? wrep : '0;
  assign resp_valid_o = state == RESP && !flush_i;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign resp_we_o    = resp_valid_o && !st && !mis_q;
  assign resp_rd_o    = resp_we_o ? rd_q : '0;
  assign misalign_o   = resp_valid_o && mis_q;
endmodule

// File: doc/kamus_lsu.md
Name: kamus_lsu

Overview:
- Load/store controller between the EX stage and the data-memory port.
- Takes the effective address that EX computed (rs1 + imm) with the memory operation, rs2 store data and destination register.
- Sequences one data-memory transaction with a req/gnt/rvalid handshake and generates byte enables and store-lane replication.
- Returns sign/zero-extended load data to writeback and holds the pipeline via busy_o.

Parameters:
- ADDR_W, 32, data-memory address width.
- RD_W, 5, destination register index width.

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  EX presents a memory operation
- req_ready_o  output  1  LSU can accept (high only in IDLE)
- op_i  input  lsu_op_t(4)  LB/LH/LW/LBU/LHU/SB/SH/SW
- addr_i  input  ADDR_W  effective address from EX
- wdata_i  input  32  rs2 value for stores
- rd_i  input  RD_W  load destination
- flush_i  input  1  kill the in-flight operation
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  32  formatted load data (0 for stores)
- resp_rd_o  output  RD_W  destination of the completing load
- resp_we_o  output  1  register write required (loads only)
- busy_o  output  1  operation in flight; EX/ID stall
- misalign_o  output  1  misaligned-access fault (optional feature only; tied 0 otherwise)
- dmem_req_o  output  1  memory request
- dmem_we_o  output  1  write strobe
- dmem_be_o  output  4  byte enables
- dmem_addr_o  output  ADDR_W  word-aligned address, low 2 bits always 0
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  response (loads and stores)
- dmem_rdata_i  input  32  read word

Behaviour:
- Reset state:
  - All outputs 0, except req_ready_o = 1.
  - FSM in IDLE.
  - Reset mid-transaction drops everything. No response pulse is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: req_valid_i && req_ready_o accepts the operation and registers op, addr, wdata and rd. Next state is REQ.
  - REQ: dmem_req_o = 1 and the address/be/we/wdata are held stable until dmem_gnt_i. On gnt, go to WAIT.
  - WAIT: on dmem_rvalid_i, register the formatted data and go to RESP.
  - RESP: resp_valid_o = 1 for exactly one cycle, then IDLE.
- busy_o = (state != IDLE).
- Best-case timing: accept at cycle 0, dmem_req_o at cycle 1, gnt at cycle 1, rvalid at cycle 2, resp_valid_o at cycle 3.
- Byte enables:
  - SB: be = 1 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated ×2.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, we = 0.
- Load formatting:
  - Byte lane selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store completion: resp_valid_o with resp_we_o = 0 and resp_rdata_o = 0.
- flush_i:
  - In IDLE: no effect, and it also blocks acceptance in that cycle.
  - In REQ before gnt: dmem_req_o drops next cycle and the FSM returns to IDLE. No response.
  - In REQ with gnt in the same cycle, or in WAIT: the transaction is marked killed. The FSM still waits for rvalid, then returns to IDLE with no resp_valid_o.
  - In RESP: the response is suppressed.
- gnt and rvalid in the same cycle while in REQ: treat as gnt only. rvalid is only sampled in WAIT; the memory guarantees rvalid ≥ 1 cycle after gnt.
- Without the optional feature, misaligned low address bits are ignored:
  - Halfword uses addr[1].
  - Word is forced aligned.

Optional Feature:
- Macro: KAMUS_LSU_MISALIGN_TRAP_EN
- Defined: an accepted LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, issues no memory request.
  - FSM goes IDLE → RESP.
  - In RESP: misalign_o = 1 together with resp_valid_o, resp_we_o = 0, resp_rdata_o = faulting address.
  - Trap handling consumes this as the bad address.
- Undefined: misalign_o tied 0 and accesses are issued with the low bits ignored.

Decomposition:
- kamus_pkg holds:
  - lsu_op_t enum (LB, LH, LW, LBU, LHU, SB, SH, SW)
  - lsu_state_e
  - helper function is_store(op)
  - constants BE_ALL = 4'b1111 and BE_NONE = 4'b0000
- Sub-module kamus_lsu_align (combinational): store be/wdata generation and load extraction/extension. It is instantiated once, and the bench tests it standalone.

Test Plan:
- LW at addr 0x100, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF → dmem_addr_o = 0x100, be = 0xF, resp_valid_o at cycle 3, resp_rdata_o = 0xDEADBEEF, resp_we_o = 1.
- LB at 0x103, rdata 0x80FF_0000 → resp_rdata_o = 0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x101, wdata 0x000000AB → be = 4'b0010, dmem_wdata_o = 0xABABABAB, we = 1. SH at 0x102 with 0x1234 → be = 4'b1100, wdata = 0x12341234.
- gnt held low for 5 cycles → dmem_req_o and the address stay stable, busy_o = 1, req_ready_o = 0 throughout. Then gnt → normal completion.
- flush_i in WAIT, then rvalid → no resp_valid_o; req_ready_o returns to 1 the next cycle. Assert rst_i mid-REQ → dmem_req_o = 0 immediately.
- With KAMUS_LSU_MISALIGN_TRAP_EN, LW at 0x102 → dmem_req_o never asserted, misalign_o = resp_valid_o = 1, resp_rdata_o = 0x102. Without the macro, the same stimulus issues an access at 0x100.
